mips_bus_arbiter: RTL

- Shares the CPU's single Avalon memory-mapped master port between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Fairness is round-robin.
- It latches the winner's request, drives it on the bus until waitrequest drops, and returns read data with a one-cycle done pulse.
- A watchdog aborts a transfer whose slave never releases waitrequest.

---
 rtl/mips_bus_pkg.sv | 20 ++
 rtl/mips_bus_rr_pick.sv | 20 ++
 rtl/mips_bus_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-port MIPS Avalon bus arbiter.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } bus_req_t;

    localparam int PORT_IFETCH = 0;
    localparam int PORT_DATA   = 1;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module mips_bus_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-MM master between instruction fetch (port 0) and data
// (port 1), with round-robin fairness and a waitrequest watchdog.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_done,
    output logic [31:0] m0_readdata,

    input  logic        m1_req,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_done,
    output logic [31:0] m1_readdata,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_error
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

    state_t                state_reg, state_next;
    logic                  last_grant_reg, last_grant_next;
    logic                  port_reg, port_next;
    bus_req_t              bus_reg, bus_next;
    logic                  read_reg, read_next;
    logic                  write_reg, write_next;
    logic [1:0]            done_reg, done_next;
    logic [1:0][31:0]      rdata_reg, rdata_next;
    logic                  bus_error_reg, bus_error_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [CNT_W-1:0]      cnt_inc;

    bus_req_t              port_req [2];
    logic                  grant_valid;
    logic                  grant_idx;

    assign port_req[PORT_IFETCH] = '{write: m0_write, addr: m0_addr,
                                     writedata: m0_writedata, byteenable: m0_byteenable};
    assign port_req[PORT_DATA]   = '{write: m1_write, addr: m1_addr,
                                     writedata: m1_writedata, byteenable: m1_byteenable};

    mips_bus_rr_pick u_pick (
        .req         ({m1_req, m0_req}),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        port_next       = port_reg;
        bus_next        = bus_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        done_next       = 2'b00;
        rdata_next      = rdata_reg;
        bus_error_next  = bus_error_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    bus_next        = port_req[grant_idx];
                    read_next       = ~port_req[grant_idx].write;
                    write_next      = port_req[grant_idx].write;
                    last_grant_next = grant_idx;
                    port_next       = grant_idx;
                    cnt_next        = '0;
                    state_next      = ACCESS;
                end
            end

            ACCESS: begin
                if (!waitrequest) begin
                    read_next             = 1'b0;
                    write_next            = 1'b0;
                    done_next[port_reg]   = 1'b1;
                    rdata_next[port_reg]  = read_reg ? readdata : 32'd0;
                    state_next            = RESP;
                end else begin
                    cnt_next = cnt_inc;
                    // Abort once the stall count reaches the limit; the
                    // requester still gets its done pulse so it never hangs.
                    if (WDOG_EN && (cnt_inc == TIMEOUT_VAL)) begin
                        read_next            = 1'b0;
                        write_next           = 1'b0;
                        bus_error_next       = 1'b1;
                        done_next[port_reg]  = 1'b1;
                        rdata_next[port_reg] = 32'd0;
                        state_next           = RESP;
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            port_reg       <= 1'b0;
            bus_reg        <= '0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            done_reg       <= 2'b00;
            rdata_reg      <= '0;
            bus_error_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            port_reg       <= port_next;
            bus_reg        <= bus_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            done_reg       <= done_next;
            rdata_reg      <= rdata_next;
            bus_error_reg  <= bus_error_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign address     = bus_reg.addr;
    assign writedata   = bus_reg.writedata;
    assign byteenable  = bus_reg.byteenable;
    assign read        = read_reg;
    assign write       = write_reg;
    assign bus_error   = bus_error_reg;
    assign m0_done     = done_reg[PORT_IFETCH];
    assign m1_done     = done_reg[PORT_DATA];
    assign m0_readdata = rdata_reg[PORT_IFETCH];
    assign m1_readdata = rdata_reg[PORT_DATA];

endmodule
